mvm_bitserial: RTL and testbench

Parametrised successor to the single-shot crossbar MVM: a weight-stationary XBAR_SIZE x XBAR_SIZE crossbar engine.
- Inputs are streamed DAC_BITS per cycle, LSB slice first.
- Per-column shift-add accumulators combine the slices.
- The final result is wrapped or saturated to OUT_BITS.
- Sits inside the tile datapath between the input register file and the output/ALU stage.
- Includes row-addressed weight programming and a start/busy/done handshake.

---
 rtl/mvm_pkg.sv | 42 ++++
 rtl/mvm_bitserial_if.sv | 30 +++
 rtl/mvm_slice_dot.sv | 23 ++
 rtl/mvm_bitserial.sv | 153 +++++++++++++++
 tb/tb_mvm_bitserial.sv | 385 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mvm_pkg.sv
// Shared types and width helpers for the bit-serial crossbar MVM engine.
// Also provides the wrap/saturate reduction applied to the final column sums.
package mvm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_t;

    localparam int SAT_W = 64;

    function automatic int nslice(input int in_bits, input int dac_bits);
        return in_bits / dac_bits;
    endfunction

    function automatic int acc_bits(input int in_bits, input int wt_bits, input int xbar);
        return in_bits + wt_bits + $clog2(xbar);
    endfunction

    function automatic int psum_bits(input int dac_bits, input int wt_bits, input int xbar);
        return dac_bits + wt_bits + $clog2(xbar);
    endfunction

    // Index width that never collapses to zero for degenerate sizes.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Reduce a wide sum to out_bits: clamp to all-ones, or keep the low bits.
    function automatic logic [SAT_W-1:0] sat_wrap(input logic [SAT_W-1:0] val,
                                                  input int               out_bits,
                                                  input logic             saturate);
        logic [SAT_W-1:0] max_val;
        max_val = (SAT_W'(1) << out_bits) - SAT_W'(1);
        if (saturate) begin
            return (val > max_val) ? max_val : val;
        end
        return val & max_val;
    endfunction

endpackage

// File: rtl/mvm_bitserial_if.sv
// Control, weight-programming and result bus of the bit-serial MVM engine.
// The tile sequencer is the master; the engine is the slave.
interface mvm_bitserial_if import mvm_pkg::*; #(
    parameter int XBAR_SIZE = 4,
    parameter int IN_BITS   = 4,
    parameter int WT_BITS   = 4,
    parameter int OUT_BITS  = 8
) ();
    localparam int AW = idx_bits(XBAR_SIZE);

    logic                reset_wt;
    logic                prog_wt;
    logic [AW-1:0]       wt_row_addr;
    logic [WT_BITS-1:0]  wt_row_data [XBAR_SIZE];
    logic                mvm_start;
    logic [IN_BITS-1:0]  xbar_input  [XBAR_SIZE];
    logic                mvm_busy;
    logic                mvm_done;
    logic [OUT_BITS-1:0] xbar_output [XBAR_SIZE];

    modport master (
        output reset_wt, prog_wt, wt_row_addr, wt_row_data, mvm_start, xbar_input,
        input  mvm_busy, mvm_done, xbar_output
    );

    modport slave (
        input  reset_wt, prog_wt, wt_row_addr, wt_row_data, mvm_start, xbar_input,
        output mvm_busy, mvm_done, xbar_output
    );
endinterface

// File: rtl/mvm_slice_dot.sv
// Combinational column dot products of one input slice against the weight array.
// Output width is sized so a full column of maximal products cannot overflow.
module mvm_slice_dot import mvm_pkg::*; #(
    parameter int XBAR_SIZE = 4,
    parameter int DAC_BITS  = 1,
    parameter int WT_BITS   = 4,
    parameter int PS_BITS   = psum_bits(DAC_BITS, WT_BITS, XBAR_SIZE)
) (
    input  logic [DAC_BITS-1:0] s    [XBAR_SIZE],
    input  logic [WT_BITS-1:0]  w    [XBAR_SIZE][XBAR_SIZE],
    output logic [PS_BITS-1:0]  psum [XBAR_SIZE]
);

    always_comb begin
        for (int j = 0; j < XBAR_SIZE; j++) begin
            psum[j] = '0;
            for (int i = 0; i < XBAR_SIZE; i++) begin
                psum[j] = psum[j] + PS_BITS'(s[i]) * PS_BITS'(w[i][j]);
            end
        end
    end

endmodule

// File: rtl/mvm_bitserial.sv
// Weight-stationary crossbar MVM: input streamed DAC_BITS per cycle, LSB slice first.
// Result appears NSLICE+1 cycles after an accepted start; requests are ignored while busy.
module mvm_bitserial import mvm_pkg::*; #(
    parameter int XBAR_SIZE = 4,
    parameter int IN_BITS   = 4,
    parameter int WT_BITS   = 4,
    parameter int DAC_BITS  = 1,
    parameter int OUT_BITS  = 8,
    parameter int SATURATE  = 0
) (
    input  logic          clk,
    input  logic          reset,
    mvm_bitserial_if.slave bus
);

    localparam int NSLICE   = nslice(IN_BITS, DAC_BITS);
    localparam int ACC_BITS = acc_bits(IN_BITS, WT_BITS, XBAR_SIZE);
    localparam int PS_BITS  = psum_bits(DAC_BITS, WT_BITS, XBAR_SIZE);
    localparam int KW       = idx_bits(NSLICE);

    if (IN_BITS % DAC_BITS != 0) begin : g_bad_dac
        $error("IN_BITS must be a multiple of DAC_BITS");
    end

    state_t state, state_nxt;
    logic do_prog, do_clr, do_start, do_step, do_finish;

    logic [WT_BITS-1:0]  wt   [XBAR_SIZE][XBAR_SIZE];
    logic [IN_BITS-1:0]  x_sr [XBAR_SIZE];
    logic [DAC_BITS-1:0] s    [XBAR_SIZE];
    logic [PS_BITS-1:0]  psum [XBAR_SIZE];
    logic [ACC_BITS-1:0] acc  [XBAR_SIZE];
    logic [OUT_BITS-1:0] y_q  [XBAR_SIZE];
    logic [KW-1:0]       k;
    logic                done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Only IDLE listens to requests; prog_wt beats reset_wt beats start, losers are dropped.
    always_comb begin
        state_nxt = state;
        do_prog   = 1'b0;
        do_clr    = 1'b0;
        do_start  = 1'b0;
        do_step   = 1'b0;
        do_finish = 1'b0;
        case (state)
            IDLE: begin
                if (bus.prog_wt) begin
                    do_prog = 1'b1;
                end else if (bus.reset_wt) begin
                    do_clr = 1'b1;
                end else if (bus.mvm_start) begin
                    do_start  = 1'b1;
                    state_nxt = COMPUTE;
                end
            end
            COMPUTE: begin
                do_step = 1'b1;
                if (k == KW'(NSLICE - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                do_finish = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < XBAR_SIZE; i++) begin
            s[i] = x_sr[i][DAC_BITS-1:0];
        end
    end

    mvm_slice_dot #(
        .XBAR_SIZE (XBAR_SIZE),
        .DAC_BITS  (DAC_BITS),
        .WT_BITS   (WT_BITS),
        .PS_BITS   (PS_BITS)
    ) u_slice_dot (
        .s    (s),
        .w    (wt),
        .psum (psum)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < XBAR_SIZE; i++) begin
                x_sr[i] <= '0;
                acc[i]  <= '0;
                y_q[i]  <= '0;
                for (int j = 0; j < XBAR_SIZE; j++) begin
                    wt[i][j] <= '0;
                end
            end
            k      <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= do_finish;
            if (do_prog && (int'(bus.wt_row_addr) < XBAR_SIZE)) begin
                for (int j = 0; j < XBAR_SIZE; j++) begin
                    wt[bus.wt_row_addr][j] <= bus.wt_row_data[j];
                end
            end
            if (do_clr) begin
                for (int i = 0; i < XBAR_SIZE; i++) begin
                    for (int j = 0; j < XBAR_SIZE; j++) begin
                        wt[i][j] <= '0;
                    end
                end
            end
            if (do_start) begin
                for (int i = 0; i < XBAR_SIZE; i++) begin
                    x_sr[i] <= bus.xbar_input[i];
                    acc[i]  <= '0;
                end
                k <= '0;
            end
            // Slice k carries weight 2^(k*DAC_BITS); the shift register exposes it at the LSBs.
            if (do_step) begin
                for (int i = 0; i < XBAR_SIZE; i++) begin
                    x_sr[i] <= x_sr[i] >> DAC_BITS;
                    acc[i]  <= acc[i] + (ACC_BITS'(psum[i]) << (k * DAC_BITS));
                end
                k <= k + 1'b1;
            end
            if (do_finish) begin
                for (int i = 0; i < XBAR_SIZE; i++) begin
                    y_q[i] <= OUT_BITS'(sat_wrap(SAT_W'(acc[i]), OUT_BITS, SATURATE != 0));
                end
            end
        end
    end

    assign bus.mvm_busy = (state != IDLE);
    assign bus.mvm_done = done_q;

    always_comb begin
        for (int i = 0; i < XBAR_SIZE; i++) begin
            bus.xbar_output[i] = y_q[i];
        end
    end

endmodule

// File: tb/tb_mvm_bitserial.sv
// Drives three engine variants (wrap, saturate, 2-bit DAC) with one stimulus stream
// and compares each against a plain-arithmetic matrix-vector model.
module tb_mvm_bitserial;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;
    logic prog_wt, reset_wt, mvm_start;
    logic [1:0] wt_row_addr;
    logic [3:0] wt_row_data [N];
    logic [3:0] xbar_input  [N];

    always #5 clk = ~clk;

    mvm_bitserial_if #(.XBAR_SIZE(N), .IN_BITS(4), .WT_BITS(4), .OUT_BITS(8)) ba ();
    mvm_bitserial_if #(.XBAR_SIZE(N), .IN_BITS(4), .WT_BITS(4), .OUT_BITS(8)) bs ();
    mvm_bitserial_if #(.XBAR_SIZE(N), .IN_BITS(4), .WT_BITS(4), .OUT_BITS(8)) bd ();

    assign ba.prog_wt = prog_wt;      assign bs.prog_wt = prog_wt;      assign bd.prog_wt = prog_wt;
    assign ba.reset_wt = reset_wt;    assign bs.reset_wt = reset_wt;    assign bd.reset_wt = reset_wt;
    assign ba.mvm_start = mvm_start;  assign bs.mvm_start = mvm_start;  assign bd.mvm_start = mvm_start;
    assign ba.wt_row_addr = wt_row_addr;
    assign bs.wt_row_addr = wt_row_addr;
    assign bd.wt_row_addr = wt_row_addr;
    for (genvar g = 0; g < N; g++) begin : g_drv
        assign ba.wt_row_data[g] = wt_row_data[g];
        assign bs.wt_row_data[g] = wt_row_data[g];
        assign bd.wt_row_data[g] = wt_row_data[g];
        assign ba.xbar_input[g]  = xbar_input[g];
        assign bs.xbar_input[g]  = xbar_input[g];
        assign bd.xbar_input[g]  = xbar_input[g];
    end

    mvm_bitserial #(.XBAR_SIZE(N), .IN_BITS(4), .WT_BITS(4), .DAC_BITS(1), .OUT_BITS(8), .SATURATE(0))
        dut_a (.clk(clk), .reset(reset), .bus(ba));
    mvm_bitserial #(.XBAR_SIZE(N), .IN_BITS(4), .WT_BITS(4), .DAC_BITS(1), .OUT_BITS(8), .SATURATE(1))
        dut_s (.clk(clk), .reset(reset), .bus(bs));
    mvm_bitserial #(.XBAR_SIZE(N), .IN_BITS(4), .WT_BITS(4), .DAC_BITS(2), .OUT_BITS(8), .SATURATE(0))
        dut_d (.clk(clk), .reset(reset), .bus(bd));

    int checks = 0;
    int passes = 0;

    // Reference state: weight matrix, visible outputs, and the next result.
    int         wm  [N][N];
    logic [7:0] cur [3][N];
    logic [7:0] ny  [3][N];
    int         lat [3] = '{5, 5, 3};

    logic       obs_busy [3];
    logic       obs_done [3];
    logic [7:0] obs_y    [3][N];
    logic [7:0] hold_y   [3][N];
    logic [7:0] fin_y    [3][N];
    int         done_cyc [3];
    int         busy_cnt [3];
    int         done_cnt [3];

    task automatic model_run(input int x[N]);
        for (int j = 0; j < N; j++) begin
            int y = 0;
            for (int i = 0; i < N; i++) y += x[i] * wm[i][j];
            ny[0][j] = 8'(y % 256);
            ny[1][j] = (y > 255) ? 8'd255 : 8'(y);
            ny[2][j] = 8'(y % 256);
        end
    endtask

    task automatic sample_duts();
        obs_busy[0] = ba.mvm_busy; obs_busy[1] = bs.mvm_busy; obs_busy[2] = bd.mvm_busy;
        obs_done[0] = ba.mvm_done; obs_done[1] = bs.mvm_done; obs_done[2] = bd.mvm_done;
        for (int j = 0; j < N; j++) begin
            obs_y[0][j] = ba.xbar_output[j];
            obs_y[1][j] = bs.xbar_output[j];
            obs_y[2][j] = bd.xbar_output[j];
        end
    endtask

    task automatic prog_row(input int r, input int vals[N]);
        @(negedge clk);
        prog_wt = 1'b1;
        wt_row_addr = 2'(r);
        for (int j = 0; j < N; j++) wt_row_data[j] = 4'(vals[j]);
        @(posedge clk); #1;
        prog_wt = 1'b0;
        for (int j = 0; j < N; j++) wm[r][j] = vals[j];
    endtask

    task automatic prog_random();
        int v[N];
        for (int r = 0; r < N; r++) begin
            for (int j = 0; j < N; j++) v[j] = $urandom_range(1, 15);
            prog_row(r, v);
        end
    endtask

    // One operation; records latency, busy length, done pulses, held and final outputs.
    task automatic run_op(input int x[N], input bit disturb);
        for (int d = 0; d < 3; d++) begin
            done_cyc[d] = -1; busy_cnt[d] = 0; done_cnt[d] = 0;
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) xbar_input[i] = 4'(x[i]);
        mvm_start = 1'b1;
        @(posedge clk); #1;
        mvm_start = 1'b0;
        for (int i = 0; i < N; i++) xbar_input[i] = 4'($urandom_range(0, 15));
        for (int c = 0; c < 12; c++) begin
            sample_duts();
            if (c == 2) hold_y = obs_y;
            for (int d = 0; d < 3; d++) begin
                if (obs_busy[d]) busy_cnt[d]++;
                if (obs_done[d]) begin
                    done_cnt[d]++;
                    if (done_cyc[d] < 0) done_cyc[d] = c;
                end
            end
            if (disturb && c == 1) begin
                prog_wt = 1'b1; reset_wt = 1'b1; mvm_start = 1'b1; wt_row_addr = 2'd0;
                for (int j = 0; j < N; j++) wt_row_data[j] = 4'd15;
            end else if (disturb && c == 2) begin
                prog_wt = 1'b0; reset_wt = 1'b0; mvm_start = 1'b0;
            end
            @(posedge clk); #1;
        end
        sample_duts();
        fin_y = obs_y;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        prog_wt = 1'b0; reset_wt = 1'b0; mvm_start = 1'b0; wt_row_addr = '0;
        for (int j = 0; j < N; j++) begin wt_row_data[j] = '0; xbar_input[j] = '0; end
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wm[i][j] = 0;
        for (int d = 0; d < 3; d++) for (int j = 0; j < N; j++) cur[d][j] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0; #1;
        sample_duts();
        for (int d = 0; d < 3; d++) begin
            checks += 2;
            if (obs_busy[d] !== 1'b0) $display("FAIL reset_busy dut%0d: got %b expected 0", d, obs_busy[d]);
            else passes++;
            if (obs_done[d] !== 1'b0) $display("FAIL reset_done dut%0d: got %b expected 0", d, obs_done[d]);
            else passes++;
            for (int j = 0; j < N; j++) begin
                checks++;
                if (obs_y[d][j] !== 8'd0) $display("FAIL reset_y dut%0d[%0d]: got %0d expected 0", d, j, obs_y[d][j]);
                else passes++;
            end
        end
    endtask

    task automatic test_identity();
        int x[N] = '{1, 2, 3, 15};
        for (int r = 0; r < N; r++) begin
            int v[N];
            for (int j = 0; j < N; j++) v[j] = (r == j) ? 1 : 0;
            prog_row(r, v);
        end
        model_run(x);
        run_op(x, 1'b0);
        for (int d = 0; d < 3; d++) begin
            checks += 3;
            if (done_cyc[d] !== lat[d]) $display("FAIL ident_latency dut%0d: got %0d expected %0d", d, done_cyc[d], lat[d]);
            else passes++;
            if (busy_cnt[d] !== lat[d]) $display("FAIL ident_busy_len dut%0d: got %0d expected %0d", d, busy_cnt[d], lat[d]);
            else passes++;
            if (done_cnt[d] !== 1) $display("FAIL ident_done_pulses dut%0d: got %0d expected 1", d, done_cnt[d]);
            else passes++;
            for (int j = 0; j < N; j++) begin
                checks++;
                if (fin_y[d][j] !== ny[d][j]) $display("FAIL ident_y dut%0d[%0d]: got %0d expected %0d", d, j, fin_y[d][j], ny[d][j]);
                else passes++;
            end
        end
        cur = ny;
    endtask

    task automatic test_saturation();
        int v[N] = '{15, 15, 15, 15};
        for (int r = 0; r < N; r++) prog_row(r, v);
        model_run(v);
        run_op(v, 1'b0);
        for (int d = 0; d < 3; d++) for (int j = 0; j < N; j++) begin
            checks++;
            if (fin_y[d][j] !== ny[d][j]) $display("FAIL sat_y dut%0d[%0d]: got %0d expected %0d", d, j, fin_y[d][j], ny[d][j]);
            else passes++;
        end
        cur = ny;
    endtask

    task automatic test_dac2_pattern();
        int x[N] = '{3, 1, 2, 0};
        for (int r = 0; r < N; r++) begin
            int v[N];
            for (int j = 0; j < N; j++) v[j] = r + j;
            prog_row(r, v);
        end
        model_run(x);
        run_op(x, 1'b0);
        checks++;
        if (done_cyc[2] !== 3) $display("FAIL dac2_latency: got %0d expected 3", done_cyc[2]);
        else passes++;
        for (int d = 0; d < 3; d++) for (int j = 0; j < N; j++) begin
            checks++;
            if (fin_y[d][j] !== ny[d][j]) $display("FAIL dac2_y dut%0d[%0d]: got %0d expected %0d", d, j, fin_y[d][j], ny[d][j]);
            else passes++;
        end
        cur = ny;
    endtask

    task automatic test_collision();
        int x[N];
        int seen_busy = 0;
        @(negedge clk);
        prog_wt = 1'b1; mvm_start = 1'b1; wt_row_addr = 2'd1;
        for (int j = 0; j < N; j++) begin
            wt_row_data[j] = 4'($urandom_range(1, 15));
            wm[1][j] = int'(wt_row_data[j]);
        end
        @(posedge clk); #1;
        prog_wt = 1'b0; mvm_start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            sample_duts();
            for (int d = 0; d < 3; d++) if (obs_busy[d] || obs_done[d]) seen_busy++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen_busy !== 0) $display("FAIL collision_no_start: got %0d busy/done samples expected 0", seen_busy);
        else passes++;
        for (int i = 0; i < N; i++) x[i] = $urandom_range(1, 15);
        model_run(x);
        run_op(x, 1'b0);
        for (int d = 0; d < 3; d++) for (int j = 0; j < N; j++) begin
            checks++;
            if (fin_y[d][j] !== ny[d][j]) $display("FAIL collision_y dut%0d[%0d]: got %0d expected %0d", d, j, fin_y[d][j], ny[d][j]);
            else passes++;
        end
        cur = ny;
    endtask

    task automatic test_busy_ignore();
        int x[N];
        prog_random();
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < N; i++) x[i] = $urandom_range(1, 15);
            model_run(x);
            run_op(x, rep == 0);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (done_cnt[d] !== 1) $display("FAIL busy_ign_pulses dut%0d: got %0d expected 1", d, done_cnt[d]);
                else passes++;
                for (int j = 0; j < N; j++) begin
                    checks++;
                    if (fin_y[d][j] !== ny[d][j]) $display("FAIL busy_ign_y%0d dut%0d[%0d]: got %0d expected %0d", rep, d, j, fin_y[d][j], ny[d][j]);
                    else passes++;
                end
            end
            cur = ny;
        end
    endtask

    task automatic test_back_to_back();
        int x[N];
        int first [3];
        int second[3];
        int exp2  [3] = '{11, 11, 7};
        for (int i = 0; i < N; i++) x[i] = $urandom_range(1, 15);
        model_run(x);
        for (int d = 0; d < 3; d++) begin first[d] = -1; second[d] = -1; end
        @(negedge clk);
        for (int i = 0; i < N; i++) xbar_input[i] = 4'(x[i]);
        mvm_start = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 14; c++) begin
            sample_duts();
            for (int d = 0; d < 3; d++) if (obs_done[d]) begin
                if (first[d] < 0) first[d] = c;
                else if (second[d] < 0) second[d] = c;
            end
            @(posedge clk); #1;
        end
        mvm_start = 1'b0;
        repeat (8) @(posedge clk);
        #1 sample_duts();
        for (int d = 0; d < 3; d++) begin
            checks += 2;
            if (first[d] !== lat[d]) $display("FAIL b2b_first dut%0d: got %0d expected %0d", d, first[d], lat[d]);
            else passes++;
            if (second[d] !== exp2[d]) $display("FAIL b2b_second dut%0d: got %0d expected %0d", d, second[d], exp2[d]);
            else passes++;
            for (int j = 0; j < N; j++) begin
                checks++;
                if (obs_y[d][j] !== ny[d][j]) $display("FAIL b2b_y dut%0d[%0d]: got %0d expected %0d", d, j, obs_y[d][j], ny[d][j]);
                else passes++;
            end
        end
        cur = ny;
    endtask

    task automatic test_async_reset();
        int x[N];
        int late_done = 0;
        for (int i = 0; i < N; i++) x[i] = $urandom_range(1, 15);
        @(negedge clk);
        for (int i = 0; i < N; i++) xbar_input[i] = 4'(x[i]);
        mvm_start = 1'b1;
        @(posedge clk); #1;
        mvm_start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1 sample_duts();
        for (int d = 0; d < 3; d++) begin
            checks += 2;
            if (obs_busy[d] !== 1'b0) $display("FAIL areset_busy dut%0d: got %b expected 0", d, obs_busy[d]);
            else passes++;
            if (obs_done[d] !== 1'b0) $display("FAIL areset_done dut%0d: got %b expected 0", d, obs_done[d]);
            else passes++;
            for (int j = 0; j < N; j++) begin
                checks++;
                if (obs_y[d][j] !== 8'd0) $display("FAIL areset_y dut%0d[%0d]: got %0d expected 0", d, j, obs_y[d][j]);
                else passes++;
            end
        end
        @(negedge clk); reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            sample_duts();
            for (int d = 0; d < 3; d++) if (obs_done[d] || obs_busy[d]) late_done++;
        end
        checks++;
        if (late_done !== 0) $display("FAIL areset_no_done: got %0d busy/done samples expected 0", late_done);
        else passes++;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wm[i][j] = 0;
        for (int d = 0; d < 3; d++) for (int j = 0; j < N; j++) cur[d][j] = '0;
        for (int i = 0; i < N; i++) x[i] = $urandom_range(1, 15);
        model_run(x);
        run_op(x, 1'b0);
        for (int d = 0; d < 3; d++) for (int j = 0; j < N; j++) begin
            checks++;
            if (fin_y[d][j] !== ny[d][j]) $display("FAIL areset_then_y dut%0d[%0d]: got %0d expected %0d", d, j, fin_y[d][j], ny[d][j]);
            else passes++;
        end
        cur = ny;
    endtask

    task automatic test_reset_wt();
        int x[N];
        int x15[N] = '{15, 15, 15, 15};
        prog_random();
        for (int i = 0; i < N; i++) x[i] = $urandom_range(1, 15);
        model_run(x);
        run_op(x, 1'b0);
        cur = ny;
        @(negedge clk); reset_wt = 1'b1;
        @(posedge clk); #1; reset_wt = 1'b0;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wm[i][j] = 0;
        model_run(x15);
        run_op(x15, 1'b0);
        for (int d = 0; d < 3; d++) for (int j = 0; j < N; j++) begin
            checks += 2;
            if (hold_y[d][j] !== cur[d][j]) $display("FAIL rwt_hold dut%0d[%0d]: got %0d expected %0d", d, j, hold_y[d][j], cur[d][j]);
            else passes++;
            if (fin_y[d][j] !== ny[d][j]) $display("FAIL rwt_y dut%0d[%0d]: got %0d expected %0d", d, j, fin_y[d][j], ny[d][j]);
            else passes++;
        end
        cur = ny;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_saturation();
        test_dac2_pattern();
        test_collision();
        test_busy_ignore();
        test_back_to_back();
        test_async_reset();
        test_reset_wt();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
